// File: rtl/conv_kxk_engine_if.sv
// Handshake bundle between the job controller / pixel source (master) and conv_kxk_engine (slave).
interface conv_kxk_engine_if #(
  parameter int DW = 16
);
  logic          start;
  logic          reuse_w;
  logic [1:0]    mode;
  logic          w_valid;
  logic [DW-1:0] w_data;
  logic          i_valid;
  logic [DW-1:0] i_data;
  logic          i_ready;
  logic          o_valid;
  logic [DW-1:0] o_data;
  logic          busy;
  logic          done;

  modport master (
    output start, reuse_w, mode, w_valid, w_data, i_valid, i_data,
    input  i_ready, o_valid, o_data, busy, done
  );

  modport slave (
    input  start, reuse_w, mode, w_valid, w_data, i_valid, i_data,
    output i_ready, o_valid, o_data, busy, done
  );
endinterface

// File: rtl/conv_kxk_engine.sv
// KxK stride-1 convolution over an IMGxIMG raster stream with stored kernel, activation and
// saturation. Three pipeline registers: window, products, activated result.
module conv_kxk_engine #(
  parameter int DW   = 16,
  parameter int K    = 3,
  parameter int IMG  = 7,
  parameter int FRAC = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  conv_kxk_engine_if.slave bus
);
  localparam int NW  = K * K;
  localparam int PW  = 2 * DW;
  localparam int AW  = PW + $clog2(NW);
  localparam int RW  = (IMG > 1) ? $clog2(IMG) : 1;
  localparam int WW  = $clog2(NW);
  localparam int LAT = 3;

  localparam logic signed [AW-1:0] SAT_HI   = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_LO   = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};
  localparam logic signed [AW-1:0] RELU6_HI = AW'(6) <<< FRAC;

  typedef enum logic [2:0] {S_IDLE, S_LOAD_W, S_STREAM, S_DRAIN, S_DONE} state_t;
  typedef logic signed [DW-1:0] word_t;

  state_t               state_q, state_d;
  word_t                w_q [NW];
  word_t                w_d [NW];
  word_t                win_q [K][K];
  word_t                win_d [K][K];
  word_t                lb_mem [K-1][IMG];
  logic signed [PW-1:0] prod_q [NW];
  logic signed [PW-1:0] prod_d [NW];
  logic [WW-1:0]        wcnt_q, wcnt_d;
  logic [RW-1:0]        r_q, r_d, c_q, c_d;
  logic [1:0]           dcnt_q, dcnt_d;
  logic [1:0]           mode_q, mode_d;
  logic                 win_vld_q, win_vld_d;
  logic                 prod_vld_q, prod_vld_d;
  logic                 o_valid_q, o_valid_d;
  word_t                o_data_q, o_data_d;
  logic                 w_acc, i_acc, last_px;
  logic signed [AW-1:0] acc, y, act;

  always_comb begin
    w_acc   = bus.w_valid && (state_q == S_LOAD_W);
    i_acc   = bus.i_valid && (state_q == S_STREAM);
    last_px = (r_q == RW'(IMG-1)) && (c_q == RW'(IMG-1));
  end

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (bus.start) state_d = bus.reuse_w ? S_STREAM : S_LOAD_W;
      S_LOAD_W: if (w_acc && (wcnt_q == WW'(NW-1))) state_d = S_STREAM;
      S_STREAM: if (i_acc && last_px) state_d = S_DRAIN;
      S_DRAIN:  if (dcnt_q == 2'(LAT-2)) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.i_ready = (state_q == S_STREAM);
    bus.busy    = (state_q != S_IDLE);
    bus.done    = (state_q == S_DONE);
    bus.o_valid = o_valid_q;
    bus.o_data  = o_data_q;
  end

  // Counters, kernel store and window shift; DONE lands on the same cycle as the last result.
  always_comb begin
    wcnt_d    = wcnt_q;
    r_d       = r_q;
    c_d       = c_q;
    dcnt_d    = dcnt_q;
    mode_d    = mode_q;
    w_d       = w_q;
    win_d     = win_q;
    win_vld_d = 1'b0;
    if ((state_q == S_IDLE) && bus.start) begin
      mode_d = bus.mode;
      wcnt_d = '0;
      r_d    = '0;
      c_d    = '0;
    end
    if (w_acc) begin
      w_d[wcnt_q] = bus.w_data;
      wcnt_d      = wcnt_q + 1'b1;
    end
    if (i_acc) begin
      for (int i = 0; i < K; i++)
        for (int j = 0; j < K-1; j++) win_d[i][j] = win_q[i][j+1];
      for (int i = 0; i < K-1; i++) win_d[i][K-1] = lb_mem[K-2-i][c_q];
      win_d[K-1][K-1] = bus.i_data;
      win_vld_d = (r_q >= RW'(K-1)) && (c_q >= RW'(K-1));
      if (c_q == RW'(IMG-1)) begin
        c_d = '0;
        r_d = r_q + 1'b1;
      end else begin
        c_d = c_q + 1'b1;
      end
    end
    if (state_q == S_STREAM) dcnt_d = '0;
    else if (state_q == S_DRAIN) dcnt_d = dcnt_q + 2'd1;
  end

  always_comb begin
    for (int n = 0; n < NW; n++) prod_d[n] = PW'(win_q[n / K][n % K]) * PW'(w_q[n]);
    prod_vld_d = win_vld_q;
  end

  always_comb begin
    acc = '0;
    for (int n = 0; n < NW; n++) acc = acc + AW'(prod_q[n]);
    y   = acc >>> FRAC;
    act = y;
    if ((mode_q != 2'b00) && (y < 0)) act = '0;
    if (mode_q[1] && (act > RELU6_HI)) act = RELU6_HI;
    o_valid_d = prod_vld_q;
    o_data_d  = o_data_q;
    if (prod_vld_q) begin
      if (act > SAT_HI)      o_data_d = SAT_HI[DW-1:0];
      else if (act < SAT_LO) o_data_d = SAT_LO[DW-1:0];
      else                   o_data_d = act[DW-1:0];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      mode_q     <= '0;
      wcnt_q     <= '0;
      r_q        <= '0;
      c_q        <= '0;
      dcnt_q     <= '0;
      win_vld_q  <= 1'b0;
      prod_vld_q <= 1'b0;
      o_valid_q  <= 1'b0;
      o_data_q   <= '0;
      for (int n = 0; n < NW; n++) w_q[n] <= '0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      wcnt_q     <= wcnt_d;
      r_q        <= r_d;
      c_q        <= c_d;
      dcnt_q     <= dcnt_d;
      win_vld_q  <= win_vld_d;
      prod_vld_q <= prod_vld_d;
      o_valid_q  <= o_valid_d;
      o_data_q   <= o_data_d;
      w_q        <= w_d;
    end
  end

  // NOTE: line buffers, window and products carry no reset; only windows refilled by the
  // current job are ever flagged valid, so stale contents never reach the output.
  always_ff @(posedge clk) begin
    win_q  <= win_d;
    prod_q <= prod_d;
    if (i_acc) begin
      lb_mem[0][c_q] <= bus.i_data;
      for (int j = 1; j < K-1; j++) lb_mem[j][c_q] <= lb_mem[j-1][c_q];
    end
  end
endmodule

// File: tb/tb_conv_kxk_engine.sv
// Scoreboard bench for conv_kxk_engine (K=3, IMG=7, FRAC=8): stimulus pushes expected results,
// a negedge monitor pops and compares values and output/done timing.
module tb_conv_kxk_engine;
  localparam int DW   = 16;
  localparam int K    = 3;
  localparam int IMG  = 7;
  localparam int FRAC = 8;
  localparam int OS   = IMG - K + 1;

  typedef logic [DW-1:0] kern_t [K*K];

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int pix_idx = 0;
  int exp_done = -1;
  logic [DW-1:0] exp_q [$];
  int t_q [$];

  conv_kxk_engine_if #(.DW(DW)) bus ();

  conv_kxk_engine #(.DW(DW), .K(K), .IMG(IMG), .FRAC(FRAC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Monitor: pixel acceptances schedule output/done cycles; outputs are popped and compared.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      t_q.delete();
      exp_done = -1;
      pix_idx  = 0;
    end else begin
      if (bus.start && !bus.busy) pix_idx = 0;
      if (bus.i_valid && bus.i_ready) begin
        if ((pix_idx / IMG >= K-1) && (pix_idx % IMG >= K-1)) t_q.push_back(cyc + 3);
        if (pix_idx == IMG*IMG-1) exp_done = cyc + 3;
        pix_idx++;
      end
      if (bus.o_valid) begin
        if (exp_q.size() == 0 || t_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL o_extra: unexpected output %h at cycle %0d", bus.o_data, cyc);
        end else begin
          check("o_data", 32'(bus.o_data), 32'(exp_q.pop_front()));
          check("o_cycle", cyc, t_q.pop_front());
        end
      end
      if (bus.done) begin
        if (exp_done < 0) begin
          total++;
          bad++;
          $display("FAIL done_spurious: done pulse at cycle %0d, none expected", cyc);
        end else begin
          check("done_cycle", cyc, exp_done);
          exp_done = -1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_const(input logic [DW-1:0] v);
    repeat (OS*OS) exp_q.push_back(v);
  endtask

  task automatic push_ramp();
    for (int r = 0; r < OS; r++)
      for (int c = 0; c < OS; c++) exp_q.push_back(DW'((((r+1)*IMG) + c + 1) << FRAC));
  endtask

  task automatic start_job(input bit reuse, input logic [1:0] md);
    bus.start   = 1'b1;
    bus.reuse_w = reuse;
    bus.mode    = md;
    tick();
    bus.start   = 1'b0;
    bus.reuse_w = ~reuse;
    bus.mode    = ~md;
  endtask

  task automatic load_w(input kern_t w, input bit gaps);
    for (int n = 0; n < K*K; n++) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin
        bus.w_valid = 1'b0;
        bus.w_data  = 16'hDEAD;
        bus.i_valid = 1'b1;
        bus.i_data  = 16'h7FFF;
        tick();
      end
      bus.w_valid = 1'b1;
      bus.w_data  = w[n];
      tick();
    end
    bus.w_valid = 1'b0;
    bus.i_valid = 1'b0;
  endtask

  task automatic stream(input bit ramp, input logic [DW-1:0] val, input bit gaps,
                        input int n_px, input bit stray);
    check("i_ready_stream", 32'(bus.i_ready), 32'd1);
    for (int i = 0; i < n_px; i++) begin
      if (gaps) repeat ($urandom_range(0, 3)) begin
        bus.i_valid = 1'b0;
        bus.i_data  = 16'hBEEF;
        tick();
      end
      bus.i_valid = 1'b1;
      bus.i_data  = ramp ? DW'(i << FRAC) : val;
      if (stray && i == 10) begin
        bus.start   = 1'b1;
        bus.reuse_w = 1'b0;
        bus.mode    = 2'b00;
        bus.w_valid = 1'b1;
        bus.w_data  = 16'h7FFF;
      end
      tick();
      bus.start   = 1'b0;
      bus.w_valid = 1'b0;
    end
    bus.i_valid = 1'b0;
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      seen = bus.done;
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL done_timeout: no done within 40 cycles (cycle %0d)", cyc);
    end
    tick();
    check("outputs_left", exp_q.size(), 32'd0);
  endtask

  task automatic run_job(input bit reuse, input logic [1:0] md, input kern_t w, input bit ramp,
                         input logic [DW-1:0] val, input bit gaps, input bit stray);
    start_job(reuse, md);
    if (!reuse) load_w(w, gaps);
    stream(ramp, val, gaps, IMG*IMG, stray);
    wait_done();
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    kern_t w_one, w_neg, w_max, w_ctr;
    for (int n = 0; n < K*K; n++) begin
      w_one[n] = 16'h0100;
      w_neg[n] = 16'hFF00;
      w_max[n] = 16'h7FFF;
      w_ctr[n] = (n == (K*K)/2) ? 16'h0100 : 16'h0000;
    end
    bus.start   = 1'b0;
    bus.reuse_w = 1'b0;
    bus.mode    = 2'b00;
    bus.w_valid = 1'b0;
    bus.w_data  = '0;
    bus.i_valid = 1'b0;
    bus.i_data  = '0;

    repeat (3) tick();
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_i_ready", 32'(bus.i_ready), 32'd0);
    check("rst_o_valid", 32'(bus.o_valid), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_o_data", 32'(bus.o_data), 32'd0);
    rst_n = 1'b1;
    tick();
    tick();
    check("idle_busy", 32'(bus.busy), 32'd0);

    // Kernel reuse straight after reset: zero weights.
    push_const(16'h0000); run_job(1'b1, 2'b00, w_one, 1'b0, 16'h0100, 1'b0, 1'b0);
    push_const(16'h0600); run_job(1'b0, 2'b10, w_one, 1'b0, 16'h0100, 1'b0, 1'b0);
    push_const(16'h0900); run_job(1'b1, 2'b00, w_one, 1'b0, 16'h0100, 1'b0, 1'b0);
    // Stray start / w_valid / mode change mid-stream must be ignored.
    push_const(16'h0600); run_job(1'b1, 2'b10, w_one, 1'b0, 16'h0100, 1'b0, 1'b1);
    push_const(16'h0000); run_job(1'b0, 2'b01, w_neg, 1'b0, 16'h0100, 1'b0, 1'b0);
    push_const(16'h7FFF); run_job(1'b0, 2'b00, w_max, 1'b0, 16'h7FFF, 1'b0, 1'b0);
    push_const(16'h8000); run_job(1'b1, 2'b00, w_max, 1'b0, 16'h8000, 1'b0, 1'b0);
    // Ramp with random gaps, then the same ramp gap-free.
    push_ramp(); run_job(1'b0, 2'b00, w_ctr, 1'b1, 16'h0000, 1'b1, 1'b0);
    push_ramp(); run_job(1'b1, 2'b00, w_ctr, 1'b1, 16'h0000, 1'b0, 1'b0);

    // Abort a job after 20 pixels.
    push_const(16'h0600);
    start_job(1'b0, 2'b10);
    load_w(w_one, 1'b0);
    stream(1'b0, 16'h0100, 1'b0, 20, 1'b0);
    rst_n = 1'b0;
    #1;
    check("abort_o_valid", 32'(bus.o_valid), 32'd0);
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    check("abort_i_ready", 32'(bus.i_ready), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    repeat (4) tick();
    check("post_abort_busy", 32'(bus.busy), 32'd0);

    push_const(16'h0600); run_job(1'b0, 2'b11, w_one, 1'b0, 16'h0100, 1'b0, 1'b0);

    repeat (2) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
